// File: rtl/manager_cmd_dispatcher_pkg.sv
// Shared types and constants for the command dispatcher.
// Command/reply codes, frame bundle and FSM state encoding.
package manager_cmd_dispatcher_pkg;

   localparam int         NREGS     = 16;
   localparam logic [7:0] CMD_WRITE = 8'h57;
   localparam logic [7:0] CMD_READ  = 8'h52;
   localparam logic [7:0] RSP_ACK   = 8'h06;
   localparam logic [7:0] RSP_NAK   = 8'h15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DECODE,
      S_WRITE,
      S_READ_REQ,
      S_READ_WAIT,
      S_TX_START,
      S_TX_WAIT
   } state_t;

   typedef struct packed {
      logic [7:0] cmd;
      logic [7:0] addr;
      logic [7:0] data;
   } frame_t;

   function automatic logic is_bad(input frame_t f);
      return (f.addr >= 8'(NREGS)) ||
             ((f.cmd != CMD_WRITE) && (f.cmd != CMD_READ));
   endfunction

endpackage

// File: rtl/manager_cmd_dispatcher_if.sv
// Bus bundle between dispatcher, RX frame assembler,
// register file and UART transmitter.
interface manager_cmd_dispatcher_if;

   logic       fl_trg;
   logic [7:0] cmd_rx;
   logic [7:0] addr_rx;
   logic [7:0] data_rx;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic [7:0] reg_rdata;
   logic       tx_trg;
   logic [7:0] tx_datain;
   logic       tx_done;
   logic       busy;
   logic [7:0] drop_cnt;

   modport slave (
      input  fl_trg, cmd_rx, addr_rx, data_rx,
      input  reg_rdata, tx_done,
      output reg_we, reg_re, reg_addr, reg_wdata,
      output tx_trg, tx_datain, busy, drop_cnt
   );

   modport master (
      output fl_trg, cmd_rx, addr_rx, data_rx,
      output reg_rdata, tx_done,
      input  reg_we, reg_re, reg_addr, reg_wdata,
      input  tx_trg, tx_datain, busy, drop_cnt
   );

endinterface

// File: rtl/manager_cmd_dispatcher_frame_slot.sv
// One-entry frame buffer; a pop in the same cycle as a push
// frees the slot first so the incoming frame is kept.
module manager_cmd_dispatcher_frame_slot
   import manager_cmd_dispatcher_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst,
   input  logic   i_push,
   input  logic   i_pop,
   input  frame_t i_frame,
   output frame_t o_frame,
   output logic   o_full,
   output logic   o_drop
);

   logic   r_full;
   frame_t r_frame;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_full  <= 1'b0;
         r_frame <= '0;
      end else if (i_push && (!r_full || i_pop)) begin
         r_full  <= 1'b1;
         r_frame <= i_frame;
      end else if (i_pop) begin
         r_full  <= 1'b0;
      end
   end

   assign o_frame = r_frame;
   assign o_full  = r_full;
   assign o_drop  = i_push && r_full && !i_pop;

endmodule

// File: rtl/manager_cmd_dispatcher.sv
// Executes W/R command frames against the register file and
// queues one reply byte per accepted frame to the UART TX.
module manager_cmd_dispatcher
   import manager_cmd_dispatcher_pkg::*;
(
   input  logic                     CLK_50MHZ,
   input  logic                     RST,
   manager_cmd_dispatcher_if.slave  bus
);

   state_t     r_state;
   state_t     w_next;
   frame_t     r_act;
   frame_t     w_in;
   frame_t     w_slot;
   logic       r_prev;
   logic       w_rise;
   logic       w_full;
   logic       w_drop;
   logic       w_pop;
   logic       w_bad;
   logic       w_is_wr;
   logic       r_we;
   logic       r_re;
   logic       r_tx_trg;
   logic       r_busy;
   logic [7:0] r_txd;
   logic [7:0] r_drop;

   assign w_rise  = bus.fl_trg && !r_prev;
   assign w_in    = '{cmd: bus.cmd_rx,
                      addr: bus.addr_rx,
                      data: bus.data_rx};
   assign w_bad   = is_bad(r_act);
   assign w_is_wr = !w_bad && (r_act.cmd == CMD_WRITE);

   manager_cmd_dispatcher_frame_slot u_slot (
      .i_clk   (CLK_50MHZ),
      .i_rst   (RST),
      .i_push  (w_rise),
      .i_pop   (w_pop),
      .i_frame (w_in),
      .o_frame (w_slot),
      .o_full  (w_full),
      .o_drop  (w_drop)
   );

   always_comb begin
      w_next = r_state;
      w_pop  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_full) begin
               w_pop  = 1'b1;
               w_next = S_DECODE;
            end
         end
         S_DECODE: begin
            unique case (1'b1)
               w_bad:   w_next = S_TX_START;
               w_is_wr: w_next = S_WRITE;
               default: w_next = S_READ_REQ;
            endcase
         end
         S_WRITE:     w_next = S_TX_START;
         S_READ_REQ:  w_next = S_READ_WAIT;
         S_READ_WAIT: w_next = S_TX_START;
         S_TX_START:  w_next = S_TX_WAIT;
         S_TX_WAIT: begin
            if (bus.tx_done) w_next = S_IDLE;
         end
         default:     w_next = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they are
   // registered yet high during the state that owns them.
   always_ff @(posedge CLK_50MHZ) begin
      if (RST) begin
         r_state  <= S_IDLE;
         r_prev   <= 1'b1;
         r_act    <= '0;
         r_we     <= 1'b0;
         r_re     <= 1'b0;
         r_tx_trg <= 1'b0;
         r_busy   <= 1'b0;
         r_txd    <= '0;
         r_drop   <= '0;
      end else begin
         r_state  <= w_next;
         r_prev   <= bus.fl_trg;
         r_we     <= (w_next == S_WRITE);
         r_re     <= (w_next == S_READ_REQ);
         r_tx_trg <= (w_next == S_TX_START);
         r_busy   <= (w_next != S_IDLE);
         if (w_pop) r_act <= w_slot;
         if (r_state == S_DECODE && w_bad) r_txd <= RSP_NAK;
         if (r_state == S_WRITE) r_txd <= RSP_ACK;
         if (r_state == S_READ_WAIT) r_txd <= bus.reg_rdata;
         if (w_drop && (r_drop != 8'hFF)) r_drop <= r_drop + 8'd1;
      end
   end

   assign bus.reg_we    = r_we;
   assign bus.reg_re    = r_re;
   assign bus.reg_addr  = r_act.addr;
   assign bus.reg_wdata = r_act.data;
   assign bus.tx_trg    = r_tx_trg;
   assign bus.tx_datain = r_txd;
   assign bus.busy      = r_busy;
   assign bus.drop_cnt  = r_drop;

endmodule

// File: tb/tb_manager_cmd_dispatcher.sv
// Randomized bench for manager_cmd_dispatcher with a
// reply/register reference model and a bench register file.
module tb_manager_cmd_dispatcher;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   manager_cmd_dispatcher_if bus ();

   manager_cmd_dispatcher u_dut (
      .CLK_50MHZ (clk),
      .RST       (rst),
      .bus       (bus)
   );

   int         n_chk = 0;
   int         n_fail = 0;
   int         we_cnt = 0;
   int         re_cnt = 0;
   int         exp_drop = 0;
   logic [7:0] we_addr;
   logic [7:0] we_data;
   logic [7:0] rf [16];
   logic [7:0] mregs [16];
   logic [7:0] obs_q [$];

   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
      end else begin
         if (bus.reg_we) rf[bus.reg_addr[3:0]] <= bus.reg_wdata;
         if (bus.reg_re) bus.reg_rdata <= rf[bus.reg_addr[3:0]];
      end
   end

   always @(negedge clk) begin
      if (bus.tx_trg === 1'b1) obs_q.push_back(bus.tx_datain);
      if (bus.reg_we === 1'b1) begin
         we_cnt++;
         we_addr = bus.reg_addr;
         we_data = bus.reg_wdata;
      end
      if (bus.reg_re === 1'b1) re_cnt++;
   end

   function automatic logic [7:0] model_reply(
      input logic [7:0] c, input logic [7:0] a,
      input logic [7:0] d);
      if (a >= 8'd16 || (c != 8'h57 && c != 8'h52))
         return 8'h15;
      if (c == 8'h57) begin
         mregs[a[3:0]] = d;
         return 8'h06;
      end
      return mregs[a[3:0]];
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [7:0] c,
      input logic [7:0] a, input logic [7:0] d, input int hold);
      bus.cmd_rx  = c;
      bus.addr_rx = a;
      bus.data_rx = d;
      bus.fl_trg  = 1'b1;
      repeat (hold) tick();
      bus.fl_trg  = 1'b0;
      tick();
   endtask

   task automatic wait_reply(input string nm,
      input logic [7:0] exp);
      int t = 0;
      logic [7:0] got;
      while (obs_q.size() == 0 && t < 60) begin
         tick();
         t++;
      end
      n_chk++;
      if (obs_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: no tx_trg seen, want tx_datain=%h",
                  nm, exp);
      end else begin
         got = obs_q.pop_front();
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: tx_datain=%h want %h",
                     nm, got, exp);
         end
      end
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      tick();
   endtask

   task automatic check_latency(input string nm,
      input logic [7:0] c, input logic [7:0] a,
      input logic [7:0] d, input int exp_lat);
      int lat = 0;
      logic [7:0] exp;
      exp = model_reply(c, a, d);
      bus.cmd_rx  = c;
      bus.addr_rx = a;
      bus.data_rx = d;
      bus.fl_trg  = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         bus.fl_trg = 1'b0;
         @(negedge clk);
         if (bus.tx_trg === 1'b1 && lat == 0) lat = k;
      end
      tick();
      n_chk++;
      if (lat != exp_lat) begin
         n_fail++;
         $display("FAIL %s_latency: %0d cycles want %0d",
                  nm, lat, exp_lat);
      end
      wait_reply(nm, exp);
   endtask

   task automatic check_idle_outputs(input string nm);
      logic [57:0] got;
      got = {bus.reg_we, bus.reg_re, bus.reg_addr,
             bus.reg_wdata, bus.tx_trg, bus.tx_datain,
             bus.busy, bus.drop_cnt, 16'h0000};
      n_chk++;
      if (got !== 58'd0) begin
         n_fail++;
         $display("FAIL %s: outputs=%h want all zero", nm, got);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick();
      check_idle_outputs("reset_outputs");
      rst = 1'b0;
      repeat (2) tick();
      check_idle_outputs("post_reset_idle");
   endtask

   task automatic test_write;
      int w0 = we_cnt;
      check_latency("write", 8'h57, 8'h03, 8'hA5, 4);
      n_chk++;
      if (we_cnt - w0 != 1 || we_addr !== 8'h03 ||
          we_data !== 8'hA5) begin
         n_fail++;
         $display("FAIL write_strobe: n=%0d a=%h d=%h want 1 03 A5",
                  we_cnt - w0, we_addr, we_data);
      end
   endtask

   task automatic test_read;
      int r0 = re_cnt;
      check_latency("read", 8'h52, 8'h03, 8'h5A, 5);
      n_chk++;
      if (re_cnt - r0 != 1) begin
         n_fail++;
         $display("FAIL read_strobe: n=%0d want 1", re_cnt - r0);
      end
   endtask

   task automatic test_bad_frames;
      int w0 = we_cnt;
      int r0 = re_cnt;
      check_latency("bad_cmd", 8'h41, 8'h03, 8'h00, 3);
      check_latency("bad_addr", 8'h57, 8'h10, 8'h00, 3);
      n_chk++;
      if (we_cnt != w0 || re_cnt != r0) begin
         n_fail++;
         $display("FAIL bad_strobes: we=%0d re=%0d want 0 0",
                  we_cnt - w0, re_cnt - r0);
      end
   endtask

   task automatic test_hold_and_refill;
      logic [7:0] d0, d1, d2, ea, eb, ec;
      int t = 0;
      d0 = 8'($urandom);
      ea = model_reply(8'h57, 8'h07, d0);
      drive_frame(8'h57, 8'h07, d0, 4);
      wait_reply("hold_reply", ea);
      repeat (6) tick();
      n_chk++;
      if (obs_q.size() != 0 || bus.busy !== 1'b0 ||
          bus.drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("FAIL hold_once: q=%0d busy=%b drop=%h want 0 0 %h",
                  obs_q.size(), bus.busy, bus.drop_cnt, 8'(exp_drop));
      end
      d1 = 8'($urandom);
      d2 = 8'($urandom);
      ea = model_reply(8'h57, 8'h08, d1);
      eb = model_reply(8'h52, 8'h08, 8'h00);
      ec = model_reply(8'h57, 8'h09, d2);
      drive_frame(8'h57, 8'h08, d1, 1);
      drive_frame(8'h52, 8'h08, 8'h00, 1);
      while (obs_q.size() == 0 && t < 60) begin
         tick();
         t++;
      end
      n_chk++;
      if (obs_q.size() == 0 || obs_q[0] !== ea) begin
         n_fail++;
         $display("FAIL refill_first: q=%0d want reply %h",
                  obs_q.size(), ea);
      end
      if (obs_q.size() != 0) void'(obs_q.pop_front());
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      bus.cmd_rx  = 8'h57;
      bus.addr_rx = 8'h09;
      bus.data_rx = d2;
      bus.fl_trg  = 1'b1;
      tick();
      bus.fl_trg  = 1'b0;
      tick();
      n_chk++;
      if (bus.drop_cnt !== 8'(exp_drop)) begin
         n_fail++;
         $display("FAIL refill_drop: drop_cnt=%h want %h",
                  bus.drop_cnt, 8'(exp_drop));
      end
      wait_reply("refill_second", eb);
      wait_reply("refill_third", ec);
   endtask

   task automatic test_back_to_back;
      logic [7:0] aa, da, cb, ab, db, ea, eb;
      int sel;
      for (int it = 0; it < 300; it++) begin
         aa  = 8'($urandom_range(0, 15));
         da  = 8'($urandom);
         sel = int'($urandom_range(0, 2));
         cb  = (sel == 0) ? 8'h57 :
               (sel == 1) ? 8'h52 : 8'($urandom);
         ab  = 8'($urandom_range(0, 19));
         db  = 8'($urandom);
         ea  = model_reply(8'h57, aa, da);
         eb  = model_reply(cb, ab, db);
         drive_frame(8'h57, aa, da, 1);
         drive_frame(cb, ab, db, 1);
         drive_frame(8'($urandom), 8'($urandom), 8'($urandom), 1);
         exp_drop = (exp_drop < 255) ? exp_drop + 1 : 255;
         n_chk++;
         if (bus.drop_cnt !== 8'(exp_drop)) begin
            n_fail++;
            $display("FAIL b2b_drop it=%0d: drop_cnt=%h want %h",
                     it, bus.drop_cnt, 8'(exp_drop));
         end
         wait_reply("b2b_first", ea);
         wait_reply("b2b_second", eb);
         tick();
         n_chk++;
         if (bus.busy !== 1'b0 || obs_q.size() != 0) begin
            n_fail++;
            $display("FAIL b2b_third it=%0d: busy=%b q=%0d want 0 0",
                     it, bus.busy, obs_q.size());
         end
      end
   endtask

   task automatic test_reset_in_tx_wait;
      int t = 0;
      logic [7:0] d;
      drive_frame(8'h57, 8'h05, 8'h3C, 1);
      while (obs_q.size() == 0 && t < 60) begin
         tick();
         t++;
      end
      rst = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      bus.tx_done = 1'b1;
      tick();
      bus.tx_done = 1'b0;
      obs_q.delete();
      for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
      exp_drop = 0;
      repeat (6) tick();
      check_idle_outputs("rst_txwait_outputs");
      n_chk++;
      if (obs_q.size() != 0) begin
         n_fail++;
         $display("FAIL rst_txwait_trg: %0d tx_trg want 0",
                  obs_q.size());
      end
      d = 8'($urandom);
      check_latency("after_rst_wr", 8'h57, 8'h05, d, 4);
      check_latency("after_rst_rd", 8'h52, 8'h05, 8'h00, 5);
   endtask

   initial begin
      bus.fl_trg  = 1'b0;
      bus.cmd_rx  = 8'h00;
      bus.addr_rx = 8'h00;
      bus.data_rx = 8'h00;
      bus.tx_done = 1'b1;
      rst         = 1'b1;
      for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
      test_reset();
      bus.tx_done = 1'b0;
      test_write();
      test_read();
      test_bad_frames();
      test_hold_and_refill();
      test_back_to_back();
      test_reset_in_tx_wait();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
